// File: rtl/ldst_replay_ctrl_if.sv
// Request, bank-match and status bundle between the issue/setup side and the
// ld/st replay controller.
interface ldst_replay_ctrl_if #(
  parameter int SP_PER_MP     = 8,
  parameter int NUM_BANKS     = SP_PER_MP,
  parameter int CONTROL_WIDTH = 17,
  parameter int CNT_WIDTH     = $clog2(SP_PER_MP) + 1
);
  logic                            start;
  logic [SP_PER_MP-1:0]            mask_in;
  logic [CONTROL_WIDTH-1:0]        control_in;
  logic [NUM_BANKS*SP_PER_MP-1:0]  match_in;
  logic                            mem_ready;
  logic [SP_PER_MP-1:0]            cur_mask;
  logic [CONTROL_WIDTH-1:0]        control_out;
  logic [NUM_BANKS-1:0]            bank_en;
  logic [SP_PER_MP-1:0]            serviced;
  logic                            busy;
  logic                            done;
  logic                            err;
  logic [CNT_WIDTH-1:0]            pass_count;

  modport master (
    output start, mask_in, control_in, match_in, mem_ready,
    input  cur_mask, control_out, bank_en, serviced, busy, done, err, pass_count
  );

  modport slave (
    input  start, mask_in, control_in, match_in, mem_ready,
    output cur_mask, control_out, bank_en, serviced, busy, done, err, pass_count
  );
endinterface

// File: rtl/ldst_replay_ctrl.sv
// Replays a warp ld/st across the L1 banks, granting the lowest matching SP per
// bank each pass until every enabled thread has been serviced.
module ldst_replay_ctrl #(
  parameter int SP_PER_MP     = 8,
  parameter int NUM_BANKS     = SP_PER_MP,
  parameter int CONTROL_WIDTH = 17,
  parameter int CNT_WIDTH     = $clog2(SP_PER_MP) + 1
) (
  input  logic               clk,
  input  logic               rst,
  ldst_replay_ctrl_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam int LD_BIT = 15;
  localparam int ST_BIT = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [SP_PER_MP-1:0] ONE_SP  = {{(SP_PER_MP-1){1'b0}}, 1'b1};

  logic [0:0]               state_q,      state_d;
  logic [SP_PER_MP-1:0]     cur_mask_q,   cur_mask_d;
  logic [CONTROL_WIDTH-1:0] control_q,    control_d;
  logic [CNT_WIDTH-1:0]     pass_count_q, pass_count_d;
  logic                     done_q,       done_d;
  logic                     err_q,        err_d;

  logic [SP_PER_MP-1:0]     bank_match_s;
  logic [SP_PER_MP-1:0]     bank_grant_s;
  logic [SP_PER_MP-1:0]     serviced_s;
  logic [NUM_BANKS-1:0]     bank_en_s;
  logic [SP_PER_MP-1:0]     remaining_s;
  logic                     req_valid_s;

  // Per-bank lowest-index grant; m & (~m + 1) isolates the lowest set bit.
  always_comb begin
    bank_match_s = '0;
    bank_grant_s = '0;
    serviced_s   = '0;
    bank_en_s    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_match_s = bus.match_in[b*SP_PER_MP +: SP_PER_MP] & cur_mask_q;
      bank_grant_s = bank_match_s & (~bank_match_s + ONE_SP);
      if ((state_q == ACTIVE) && bus.mem_ready) begin
        serviced_s   = serviced_s | bank_grant_s;
        bank_en_s[b] = |bank_match_s;
      end else begin
        serviced_s   = serviced_s;
        bank_en_s[b] = 1'b0;
      end
    end
  end

  assign remaining_s = cur_mask_q & ~serviced_s;
  assign req_valid_s = (bus.mask_in != '0) &&
                       (bus.control_in[LD_BIT] || bus.control_in[ST_BIT]);

  // Next-state logic for request acceptance, replay passes and abort.
  always_comb begin
    state_d      = state_q;
    cur_mask_d   = cur_mask_q;
    control_d    = control_q;
    pass_count_d = pass_count_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pass_count_d = '0;
          if (req_valid_s) begin
            cur_mask_d = bus.mask_in;
            control_d  = bus.control_in;
            state_d    = ACTIVE;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!bus.mem_ready) begin
          state_d = ACTIVE;
        end else if (serviced_s != '0) begin
          cur_mask_d   = remaining_s;
          pass_count_d = (pass_count_q == CNT_MAX) ? pass_count_q
                                                   : pass_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          if (remaining_s == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ACTIVE;
          end
        end else begin
          // Threads remain but no bank claims them: nothing can make progress.
          err_d      = 1'b1;
          done_d     = 1'b1;
          cur_mask_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        cur_mask_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any request silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_mask_q   <= '0;
      control_q    <= '0;
      pass_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_mask_q   <= cur_mask_d;
      control_q    <= control_d;
      pass_count_q <= pass_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.cur_mask    = cur_mask_q;
  assign bus.control_out = control_q;
  assign bus.bank_en     = bank_en_s;
  assign bus.serviced    = serviced_s;
  assign bus.busy        = (state_q == ACTIVE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.pass_count  = pass_count_q;

endmodule

// File: doc/ldst_replay_ctrl.md
Name: ldst_replay_ctrl

Overview:
Sequential conflict-resolution stage paired with the per-bank ld/st setup units. It holds the warp's active ld/st mask and drives it as cur_mask into all bank setup instances. Each cycle it collects their per-bank match vectors and grants the lowest-index matching SP in every bank. It retires the granted threads and replays until every enabled thread has accessed the L1 banks, stalling issue while busy.

Parameters:
SP_PER_MP, 8, number of SPs (threads) per MP
NUM_BANKS, SP_PER_MP, number of L1 banks (one setup instance each)
CONTROL_WIDTH, 17, control bits; bit 15 = ld, bit 16 = st
CNT_WIDTH, $clog2(SP_PER_MP)+1, width of pass counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
start  input  1  new ld/st request; sampled only in IDLE
mask_in  input  SP_PER_MP  enabled-thread mask for the request
control_in  input  CONTROL_WIDTH  control bits for the request
match_in  input  NUM_BANKS*SP_PER_MP  per-bank match vectors; bank b occupies bits [b*SP_PER_MP +: SP_PER_MP]
mem_ready  input  1  L1 banks accept an access this cycle
cur_mask  output  SP_PER_MP  remaining-thread mask driven to every setup instance
control_out  output  CONTROL_WIDTH  registered control driven to setup instances
bank_en  output  NUM_BANKS  bank b performs an access this cycle
serviced  output  SP_PER_MP  one-hot-per-bank set of SPs granted this cycle
busy  output  1  stall to issue stage
done  output  1  one-cycle pulse when the request completes
err  output  1  one-cycle pulse on abort (no progress possible)
pass_count  output  CNT_WIDTH  accesses used by last or current request

Behaviour:
- States: IDLE, ACTIVE. On reset: state IDLE, cur_mask 0, control_out 0, pass_count 0; bank_en, serviced, busy, done, err all 0. Reset takes effect immediately and aborts any in-flight request without a done pulse.
- IDLE, start=1 with mask_in!=0 and (control_in[15] | control_in[16]): register cur_mask<=mask_in, control_out<=control_in, pass_count<=0; next state ACTIVE.
- IDLE, start=1 otherwise (zero mask or not ld/st): stay IDLE, pulse done next cycle, pass_count<=0, no bank access.
- start while ACTIVE is ignored; the upstream stage must hold the instruction while busy=1.
- busy = (state==ACTIVE), combinational from state.
- ACTIVE, combinational each cycle:
  - m_b = match_in bank b & cur_mask (defensive masking).
  - g_b = lowest set bit of m_b. Lowest index wins, which matches the setup unit's priority-encoder addr_sel.
  - serviced = OR of all g_b, gated by mem_ready.
  - bank_en[b] = |m_b & mem_ready.
- ACTIVE, mem_ready=0: hold all state; serviced=0, bank_en=0.
- ACTIVE, mem_ready=1 and serviced!=0:
  - cur_mask <= cur_mask & ~serviced; pass_count <= pass_count+1.
  - If the new cur_mask==0: pulse done in the next cycle and go to IDLE.
- ACTIVE, mem_ready=1 and serviced==0 (cur_mask!=0 but no bank matches, malformed): pulse err and done next cycle, clear cur_mask, go to IDLE.
- Latency: the request is accepted in cycle 0. Access passes occur in cycles 1..N, where N = max threads mapped to one bank plus mem_ready stall cycles. done is high in cycle N+1 with busy=0; a new start is accepted in that cycle.
- pass_count saturates at its max; it holds its value in IDLE until the next accepted start.
- In IDLE: cur_mask=0, so setup units produce no matches.

Test Plan:
1. SP=8, mask_in=0xFF, ld, SP i maps to bank i, mem_ready=1 -> cycle 1: serviced=0xFF, bank_en=0xFF; cycle 2: done=1, pass_count=1, busy=0.
2. mask_in=0xFF, st, all SPs map to bank 3 -> passes 1..8 serviced=0x01,0x02,...,0x80, bank_en=0x08 each pass; done in cycle 9, pass_count=8.
3. Scenario 2 with mem_ready=0 in cycles 3-5 -> cur_mask holds 0xFC, serviced=0 and bank_en=0 during cycles 3-5; done in cycle 12, pass_count=8.
4. start with control bits 15,16 = 0, mask 0xFF; then mask_in=0x00 with ld -> each gives done next cycle, busy never 1, bank_en never 1, pass_count=0.
5. Scenario 2 with rst asserted asynchronously mid-cycle 3 -> all outputs 0 immediately, no done pulse; after release a fresh start with scenario 1 completes normally.
6. ACTIVE with cur_mask=0x30, match_in all zero, mem_ready=1 -> err=1 and done=1 next cycle, cur_mask=0, state IDLE. Separately, start pulsed during ACTIVE -> ignored, cur_mask unchanged.
